// File: rtl/pipelined_fetch_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port,
// and the IF/ID register contents out.
interface pipelined_fetch_if #(
   parameter int ADDR_W = 32
);
   logic              stall;
   logic              flush;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              halt_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [31:0]       if_id_instr;
   logic [ADDR_W-1:0] if_id_pc4;
   logic              if_id_valid;
   logic              halted;
   logic [31:0]       fetch_cnt;

   modport master (
      input  stall, flush, branch_taken, branch_target, halt_req, imem_rdata,
      output imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_cnt
   );

   modport slave (
      output stall, flush, branch_taken, branch_target, halt_req, imem_rdata,
      input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_cnt
   );
endinterface

// File: rtl/pipelined_fetch.sv
// Instruction fetch stage with BOOT/RUN/HALT control and IF/ID register.
// Optional saturating fetch counter enabled by macro FETCH_STATS_EN.
module pipelined_fetch #(
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_fetch_if.master bus
);
   localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};
   localparam logic [ADDR_W-1:0] ALIGN_MASK       = {{(ADDR_W-2){1'b1}}, 2'b00};
   localparam logic [ADDR_W-1:0] PC_STEP          = ADDR_W'(4);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [31:0]       instr_reg, instr_next;
   logic [ADDR_W-1:0] pc4_reg, pc4_next;
   logic              valid_reg, valid_next;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] redirect_pc;

   assign pc_plus4    = pc_reg + PC_STEP;
   assign redirect_pc = bus.branch_target & ALIGN_MASK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_BOOT;
         pc_reg    <= RESET_PC_ALIGNED;
         instr_reg <= NOP_WORD;
         pc4_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         instr_reg <= instr_next;
         pc4_reg   <= pc4_next;
         valid_reg <= valid_next;
      end
   end

   // Bubbles leave if_id_pc4 untouched; only a real fetch rewrites it.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      instr_next = instr_reg;
      pc4_next   = pc4_reg;
      valid_next = valid_reg;
      case (state_reg)
         ST_BOOT: begin
            instr_next = NOP_WORD;
            valid_next = 1'b0;
            state_next = ST_RUN;
         end
         ST_RUN: begin
            if (bus.branch_taken) begin
               pc_next    = redirect_pc;
               instr_next = NOP_WORD;
               valid_next = 1'b0;
            end else if (bus.halt_req) begin
               state_next = ST_HALT;
               instr_next = NOP_WORD;
               valid_next = 1'b0;
            end else if (bus.flush) begin
               instr_next = NOP_WORD;
               valid_next = 1'b0;
               if (!bus.stall) begin
                  pc_next = pc_plus4;
               end
            end else if (!bus.stall) begin
               instr_next = bus.imem_rdata;
               pc4_next   = pc_plus4;
               valid_next = 1'b1;
               pc_next    = pc_plus4;
            end
         end
         ST_HALT: begin
            instr_next = NOP_WORD;
            valid_next = 1'b0;
            if (bus.branch_taken) begin
               pc_next = redirect_pc;
            end
            if (!bus.halt_req) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_BOOT;
            instr_next = NOP_WORD;
            valid_next = 1'b0;
         end
      endcase
   end

   assign bus.imem_addr   = pc_reg;
   assign bus.if_id_instr = instr_reg;
   assign bus.if_id_pc4   = pc4_reg;
   assign bus.if_id_valid = valid_reg;
   assign bus.halted      = (state_reg == ST_HALT);

`ifdef FETCH_STATS_EN
   logic        fetch_fire;
   logic [31:0] fetch_cnt_reg;

   assign fetch_fire = (state_reg == ST_RUN) && !bus.branch_taken && !bus.halt_req
                       && !bus.flush && !bus.stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_reg <= 32'd0;
      end else if (fetch_fire && (fetch_cnt_reg != 32'hFFFF_FFFF)) begin
         fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
   end

   assign bus.fetch_cnt = fetch_cnt_reg;
`else
   assign bus.fetch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipelined_fetch.sv
// Randomized scoreboard bench for pipelined_fetch: a spec-level model pushes
// the expected post-edge outputs, a monitor pops and compares after each edge.
module tb_pipelined_fetch;
   localparam int          ADDR_W     = 16;
   localparam logic [31:0] RESET_PC   = 32'h0000_0043;
   localparam logic [31:0] NOP_WORD   = 32'hDEAD_0013;
   localparam logic [31:0] RST_PC_EXP = 32'h0000_0040;
   localparam logic [31:0] ADDR_MASK  = 32'h0000_FFFF;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        halted;
      logic [31:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_txn = 0;
   exp_t sb[$];

   int          m_mode;
   logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
   logic        m_valid;

   pipelined_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   pipelined_fetch #(
      .ADDR_W  (ADDR_W),
      .RESET_PC(RESET_PC),
      .NOP_WORD(NOP_WORD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   assign bus.imem_rdata = imem_word(32'(bus.imem_addr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = RST_PC_EXP;
      m_instr = NOP_WORD;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
      m_cnt   = 32'd0;
   endtask

   task automatic model_bubble();
      m_instr = NOP_WORD;
      m_valid = 1'b0;
   endtask

   // Mode 0 = BOOT, 1 = RUN, 2 = HALT; priority branch > halt > flush > stall.
   task automatic model_edge(input logic st, input logic fl, input logic br,
                             input logic [31:0] tgt, input logic hl);
      logic [31:0] seq_pc;
      logic [31:0] redirect;
      seq_pc   = (m_pc + 32'd4) & ADDR_MASK;
      redirect = tgt & ADDR_MASK & ~32'd3;
      if (m_mode == 0) begin
         model_bubble();
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (br) begin
            m_pc = redirect;
            model_bubble();
         end else if (hl) begin
            m_mode = 2;
            model_bubble();
         end else if (fl) begin
            model_bubble();
            if (!st) m_pc = seq_pc;
         end else if (!st) begin
            m_instr = imem_word(m_pc);
            m_pc4   = seq_pc;
            m_valid = 1'b1;
            m_pc    = seq_pc;
`ifdef FETCH_STATS_EN
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
         end
      end else begin
         model_bubble();
         if (br) m_pc = redirect;
         if (!hl) m_mode = 1;
      end
   endtask

   // Called at posedge+2: drive inputs, predict the state after the next edge.
   task automatic step(input logic r, input logic st, input logic fl, input logic br,
                       input logic [31:0] tgt, input logic hl);
      exp_t e;
      rst_n             = r;
      bus.stall         = st;
      bus.flush         = fl;
      bus.branch_taken  = br;
      bus.branch_target = tgt[ADDR_W-1:0];
      bus.halt_req      = hl;
      #1;
      if (!r) begin
         chk("async_rst_imem_addr", 32'(bus.imem_addr), RST_PC_EXP);
         chk("async_rst_valid", 32'(bus.if_id_valid), 32'd0);
         chk("async_rst_halted", 32'(bus.halted), 32'd0);
         chk("async_rst_instr", bus.if_id_instr, NOP_WORD);
         chk("async_rst_cnt", bus.fetch_cnt, 32'd0);
         model_reset();
      end else begin
         chk("imem_addr_stable", 32'(bus.imem_addr), m_pc);
         model_edge(st, fl, br, tgt, hl);
      end
      e.pc     = m_pc;
      e.instr  = m_instr;
      e.pc4    = m_pc4;
      e.valid  = m_valid;
      e.halted = (m_mode == 2);
      e.cnt    = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_txn++;
            $display("txn %0d: pc=%h instr=%h pc4=%h valid=%b halted=%b cnt=%0d",
                     n_txn, bus.imem_addr, bus.if_id_instr, bus.if_id_pc4,
                     bus.if_id_valid, bus.halted, bus.fetch_cnt);
            chk("imem_addr", 32'(bus.imem_addr), e.pc);
            chk("if_id_instr", bus.if_id_instr, e.instr);
            chk("if_id_pc4", 32'(bus.if_id_pc4), e.pc4);
            chk("if_id_valid", 32'(bus.if_id_valid), 32'(e.valid));
            chk("halted", 32'(bus.halted), 32'(e.halted));
            chk("fetch_cnt", bus.fetch_cnt, e.cnt);
         end
      end
   end

   initial begin : driver
      logic st, fl, br, hl, r;
      logic [31:0] tgt;
      bus.stall         = 1'b0;
      bus.flush         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.halt_req      = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      // Reset release: BOOT bubble, then word at 0x40 with pc4 0x44.
      step(1, 0, 0, 0, 0, 0);
      repeat (4) step(1, 0, 0, 0, 0, 0);
      // PC now 0x50: hold for three stalled cycles, then resume.
      repeat (3) step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      // Branch beats stall and aligns 0x103 down to 0x100.
      step(1, 1, 0, 1, 32'h103, 0);
      step(1, 0, 0, 0, 0, 0);
      // Flush with and without stall.
      step(1, 0, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      // Two halt cycles then resume.
      repeat (2) step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      // Reset pulsed while halted.
      repeat (2) step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      // Address wrap at the top of the 16-bit space.
      step(1, 0, 0, 1, 32'hFFFE, 0);
      repeat (2) step(1, 0, 0, 0, 0, 0);
      // Branch while halted.
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 1, 32'h0208, 1);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 79) != 0);
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 7) == 0);
         br  = ($urandom_range(0, 9) == 0);
         hl  = ($urandom_range(0, 11) == 0);
         tgt = $urandom;
         step(r, st, fl, br, tgt, hl);
      end
      step(1, 0, 0, 0, 0, 0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
